// File: rtl/parking_gate_controller.sv
// Parking gate controller: debounces the entry/exit loop sensors, asks the
// parking_controller space flags before opening the entry barrier, sequences
// both barriers and emits one single-cycle car_entered/car_exited strobe per
// car that actually passes a gate. Exit strobes win arbitration; a losing
// entry strobe is held and issued the following cycle.
// Optional build macro: GATE_STATS_EN adds deny_count and timeout_count.
// Raw sensors are assumed to be synchronous to clk.
module parking_gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned OPEN_TIMEOUT    = 1000,
  parameter int unsigned TIMER_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arrive_sensor,
  input  logic        entry_pass_sensor,
  input  logic        card_uni,
  input  logic        depart_sensor,
  input  logic        exit_pass_sensor,
  input  logic        depart_uni,
  input  logic        is_uni_vacated_space,
  input  logic        is_vacated_space,
  output logic        car_entered,
  output logic        is_uni_car_entered,
  output logic        car_exited,
  output logic        is_uni_car_exited,
  output logic        entry_barrier_open,
  output logic        exit_barrier_open,
  output logic        entry_denied
`ifdef GATE_STATS_EN
  ,
  output logic [15:0] deny_count,
  output logic [15:0] timeout_count
`endif
);

  localparam int unsigned NumSens = 4;
  localparam int unsigned DbCntW  = $clog2(DEBOUNCE_CYCLES + 1);

  // Sensor indices into the debounce vectors
  localparam int unsigned SArrive    = 0;
  localparam int unsigned SEntryPass = 1;
  localparam int unsigned SDepart    = 2;
  localparam int unsigned SExitPass  = 3;

  localparam logic [DbCntW-1:0]  DbLast    = DbCntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(OPEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    EIdle,
    ECheck,
    EDeny,
    EOpen,
    EStrobe
  } entry_state_e;

  typedef enum logic [1:0] {
    XIdle,
    XOpen,
    XStrobe
  } exit_state_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [NumSens-1:0] raw;
  logic [NumSens-1:0] lvl_q;
  logic [NumSens-1:0] prev_q;
  logic [NumSens-1:0] rise;
  logic [DbCntW-1:0]  db_cnt_q [NumSens];

  assign raw  = {exit_pass_sensor, depart_sensor, entry_pass_sensor, arrive_sensor};
  assign rise = lvl_q & ~prev_q;

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q  <= '0;
      prev_q <= '0;
      for (int i = 0; i < NumSens; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      prev_q <= lvl_q;
      for (int i = 0; i < NumSens; i++) begin
        if (raw[i] != lvl_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            lvl_q[i]    <= raw[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe requests and arbitration
  // ---------------------------------------------------------------------------
  entry_state_e       e_state_q;
  exit_state_e        x_state_q;
  logic [TIMER_W-1:0] e_timer_q;
  logic [TIMER_W-1:0] x_timer_q;
  logic               e_uni_q;
  logic               x_uni_q;

  logic e_pass_ev, x_pass_ev;
  logic e_req, x_req;
  logic e_grant, x_grant;
  logic e_timeout, x_timeout;
  logic e_space_ok;

  // Requests come from a fresh pass event or a strobe still waiting for its slot
  always_comb begin
    e_pass_ev  = (e_state_q == EOpen) && rise[SEntryPass];
    x_pass_ev  = (x_state_q == XOpen) && rise[SExitPass];
    e_req      = e_pass_ev || ((e_state_q == EStrobe) && !car_entered);
    x_req      = x_pass_ev || ((x_state_q == XStrobe) && !car_exited);
    x_grant    = x_req;
    e_grant    = e_req && !x_req;
    // A pass event in the final open cycle takes precedence over the timeout
    e_timeout  = (e_state_q == EOpen) && !rise[SEntryPass] && (e_timer_q == TimerLast);
    x_timeout  = (x_state_q == XOpen) && !rise[SExitPass] && (x_timer_q == TimerLast);
    e_space_ok = e_uni_q ? is_uni_vacated_space : is_vacated_space;
  end

  // ---------------------------------------------------------------------------
  // Entry FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_state_q          <= EIdle;
      e_timer_q          <= '0;
      e_uni_q            <= 1'b0;
      entry_barrier_open <= 1'b0;
      entry_denied       <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
    end else begin
      entry_denied       <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      unique case (e_state_q)
        EIdle: begin
          if (rise[SArrive]) begin
            e_uni_q   <= card_uni;
            e_state_q <= ECheck;
          end
        end
        ECheck: begin
          if (e_space_ok) begin
            e_state_q          <= EOpen;
            e_timer_q          <= '0;
            entry_barrier_open <= 1'b1;
          end else begin
            e_state_q    <= EDeny;
            entry_denied <= 1'b1;
          end
        end
        EDeny: begin
          e_state_q <= EIdle;
        end
        EOpen: begin
          if (e_pass_ev) begin
            entry_barrier_open <= 1'b0;
            e_state_q          <= EStrobe;
            if (e_grant) begin
              car_entered        <= 1'b1;
              is_uni_car_entered <= e_uni_q;
            end
          end else if (e_timeout) begin
            entry_barrier_open <= 1'b0;
            e_state_q          <= EIdle;
          end else begin
            e_timer_q <= e_timer_q + 1'b1;
          end
        end
        EStrobe: begin
          // Strobe already on the wire this cycle: done. Otherwise retry the slot.
          if (car_entered) begin
            e_state_q <= EIdle;
          end else if (e_grant) begin
            car_entered        <= 1'b1;
            is_uni_car_entered <= e_uni_q;
          end
        end
        default: begin
          e_state_q          <= EIdle;
          entry_barrier_open <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Exit FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_state_q         <= XIdle;
      x_timer_q         <= '0;
      x_uni_q           <= 1'b0;
      exit_barrier_open <= 1'b0;
      car_exited        <= 1'b0;
      is_uni_car_exited <= 1'b0;
    end else begin
      car_exited        <= 1'b0;
      is_uni_car_exited <= 1'b0;
      unique case (x_state_q)
        XIdle: begin
          if (rise[SDepart]) begin
            x_uni_q           <= depart_uni;
            x_timer_q         <= '0;
            exit_barrier_open <= 1'b1;
            x_state_q         <= XOpen;
          end
        end
        XOpen: begin
          if (x_pass_ev) begin
            exit_barrier_open <= 1'b0;
            x_state_q         <= XStrobe;
            if (x_grant) begin
              car_exited        <= 1'b1;
              is_uni_car_exited <= x_uni_q;
            end
          end else if (x_timeout) begin
            exit_barrier_open <= 1'b0;
            x_state_q         <= XIdle;
          end else begin
            x_timer_q <= x_timer_q + 1'b1;
          end
        end
        XStrobe: begin
          if (car_exited) begin
            x_state_q <= XIdle;
          end else if (x_grant) begin
            car_exited        <= 1'b1;
            is_uni_car_exited <= x_uni_q;
          end
        end
        default: begin
          x_state_q         <= XIdle;
          exit_barrier_open <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATE_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  logic [16:0] to_sum;

  always_comb begin
    to_sum = {1'b0, timeout_count} + {15'd0, e_timeout} + {15'd0, x_timeout};
  end

  // Count each denial pulse and each barrier timeout, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deny_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (entry_denied && (deny_count != 16'hFFFF)) begin
        deny_count <= deny_count + 16'd1;
      end
      timeout_count <= to_sum[16] ? 16'hFFFF : to_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Gate-side initiator for parking_controller: it drives that block's car_entered/is_uni_car_entered and car_exited/is_uni_car_exited strobes.
- Debounces the raw loop sensors and checks the controller's space flags before opening the entry barrier.
- Sequences the entry and exit barriers.
- Emits exactly one single-cycle strobe per car that physically passes a gate.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required for a sensor level change to be accepted (min 1).
- OPEN_TIMEOUT, 1000: cycles a barrier stays open waiting for the pass sensor before auto-closing.
- TIMER_W, 16: width of the open-timer; must hold OPEN_TIMEOUT-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arrive_sensor  in  1  raw entry-loop presence (car waiting at entry)
- entry_pass_sensor  in  1  raw sensor behind the entry barrier
- card_uni  in  1  1 = arriving car shows a university card; sampled on arrival
- depart_sensor  in  1  raw exit-loop presence
- exit_pass_sensor  in  1  raw sensor behind the exit barrier
- depart_uni  in  1  1 = departing car is a university car; sampled on departure
- is_uni_vacated_space  in  1  from parking_controller: university space free
- is_vacated_space  in  1  from parking_controller: free (non-uni) space free
- car_entered  out  1  single-cycle entry strobe to parking_controller
- is_uni_car_entered  out  1  qualifier; valid only while car_entered=1, else 0
- car_exited  out  1  single-cycle exit strobe
- is_uni_car_exited  out  1  qualifier; valid only while car_exited=1, else 0
- entry_barrier_open  out  1  entry barrier actuator
- exit_barrier_open  out  1  exit barrier actuator
- entry_denied  out  1  one-cycle pulse when entry is refused for lack of space

Behaviour:
- Reset:
  - All outputs are 0; both FSMs go to IDLE; timers and debouncers clear.
  - Debounced levels reset to 0.
  - Reset mid-operation closes both barriers immediately and drops any pending strobe.
- Debounce, per sensor:
  - The debounced level flips only after the raw input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
  - A rising event is a registered 0→1 transition of the debounced level.
- Entry FSM states: E_IDLE, E_CHECK, E_DENY, E_OPEN, E_STROBE.
  - E_IDLE: on an arrive rising event, latch card_uni into uni_q and go to E_CHECK. Events in other states are ignored; a waiting car must re-trigger.
  - E_CHECK (1 cycle): the granted flag is is_uni_vacated_space when uni_q=1, otherwise is_vacated_space. Granted goes to E_OPEN; not granted goes to E_DENY.
  - E_DENY: entry_denied=1 for this cycle, then E_IDLE.
  - E_OPEN: entry_barrier_open=1 and the timer increments. An entry_pass rising event goes to E_STROBE. If the timer reaches OPEN_TIMEOUT-1 first, go to E_IDLE with no strobe. A pass event and the timeout in the same cycle count as a pass.
  - E_STROBE: the barrier closes and an entry request is raised. When granted, car_entered=1 and is_uni_car_entered=uni_q for exactly one cycle, then E_IDLE.
- Exit FSM states: X_IDLE, X_OPEN, X_STROBE.
  - X_IDLE: on a depart rising event, latch depart_uni and go to X_OPEN. No space check is made.
  - X_OPEN and X_STROBE: identical to the entry path, using exit_pass_sensor and the same OPEN_TIMEOUT.
- Strobe arbiter:
  - Entry and exit strobes are never asserted in the same cycle, because parking_controller counts one event per cycle.
  - When both are requested in the same cycle, exit wins; entry is granted the next cycle.
  - No request is ever dropped.
- Latency:
  - From a pass rising event in cycle N, the strobe asserts in cycle N+1, or N+2 if it loses arbitration.
  - From arrival rising event to barrier open: 2 cycles when space is available.
- Outputs: all are registered, glitch-free, with no combinational path from inputs to outputs.
- Flags: space flags are sampled only in E_CHECK. A flag change while the barrier is open does not revoke the entry.

Optional Feature:
- GATE_STATS_EN defined:
  - Adds output deny_count[15:0] (increments on each entry_denied) and output timeout_count[15:0] (increments on each entry or exit timeout; +2 if both time out in the same cycle).
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=4): a 3-cycle arrive glitch → no state change. A 4-cycle-stable high, uni card, is_uni_vacated_space=1 → entry_barrier_open 2 cycles after the debounced edge.
- Full entry: pass sensor high for 4 cycles → exactly one car_entered pulse with is_uni_car_entered=1; barrier closes; a second pulse never appears.
- Denial: free car with is_vacated_space=0 → entry_denied one-cycle pulse, barrier stays 0, car_entered stays 0.
- Timeout (OPEN_TIMEOUT=100): open the entry and never assert pass → barrier drops after 100 cycles, no strobe; with GATE_STATS_EN, timeout_count=1.
- Collision: entry and exit pass events in the same cycle → car_exited in cycle N+1, car_entered in N+2, never overlapping.
- Reset mid-open: rst asserted while exit_barrier_open=1 → all outputs 0 asynchronously; after release, no stale strobe.
